// File: rtl/pulse_collector_pkg.sv
// Shared types and helpers for the pulse collector: FSM state encoding and saturating add.
package pulse_collector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OFFER = 2'd2
    } state_t;

    // Result clamps at 2**width-1; callers truncate to their own width.
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned width);
        int unsigned max_val;
        int unsigned sum;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        sum     = a + b;
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage

// File: rtl/pulse_collector_sat_cnt.sv
// CW-bit saturating counter with synchronous load (load wins over inc) and a drop flag
// that is high when an increment is requested while already at the maximum.
module pulse_collector_sat_cnt
    import pulse_collector_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] value,
    output logic          drop
);

    assign drop = inc & ~load & (value == '1);

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= CW'(sat_add(32'(value), 32'd1, 32'(CW)));
        end
    end

endmodule

// File: rtl/pulse_collector.sv
// Counts rising edges of pulse_in over a WINDOW-edge batch and offers the count over valid/ready.
// Optional PULSE_COLLECTOR_OVF_EN adds a per-batch sticky overflow output (ovf).
module pulse_collector
    import pulse_collector_pkg::*;
#(
    parameter int CW     = 4,
    parameter int WINDOW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pulse_in,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [CW-1:0] out_count,
    output logic          busy
`ifdef PULSE_COLLECTOR_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam int WW = ($clog2(WINDOW) > 0) ? $clog2(WINDOW) : 1;

    state_t        state, state_nxt;
    logic [WW-1:0] timer, timer_nxt;
    logic          pulse_q, ev, hs, reload;
    logic          cnt_inc, cnt_load, cnt_drop;
    logic          pend_inc, pend_load, pend_drop;
    logic [CW-1:0] cnt_load_val, cnt, pend;

    assign ev        = pulse_in & ~pulse_q;
    assign out_valid = (state == OFFER);
    assign hs        = out_valid & out_ready;
    assign reload    = (pend != '0) | ev;
    assign busy      = (state != IDLE);
    assign out_count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            pulse_q <= pulse_in;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        cnt_inc      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        pend_inc     = 1'b0;
        pend_load    = 1'b0;
        case (state)
            IDLE: begin
                if (ev) begin
                    state_nxt    = ACCUM;
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(1);
                    timer_nxt    = WW'(WINDOW - 1);
                end
            end
            ACCUM: begin
                cnt_inc = ev;
                if (timer == '0) state_nxt = OFFER;
                else             timer_nxt = timer - 1'b1;
            end
            OFFER: begin
                if (hs) begin
                    // Events seen while offering seed the next batch; the handshake edge's own event too.
                    pend_load    = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(sat_add(32'(pend), 32'(ev), 32'(CW)));
                    if (reload) begin
                        state_nxt = ACCUM;
                        timer_nxt = WW'(WINDOW - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    pend_inc = ev;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    pulse_collector_sat_cnt #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (cnt_inc),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .value    (cnt),
        .drop     (cnt_drop)
    );

    pulse_collector_sat_cnt #(.CW(CW)) u_pend (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pend_inc),
        .load     (pend_load),
        .load_val ('0),
        .value    (pend),
        .drop     (pend_drop)
    );

`ifdef PULSE_COLLECTOR_OVF_EN
    logic ovf_q, pend_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q      <= 1'b0;
            pend_ovf_q <= 1'b0;
        end else if (hs) begin
            ovf_q      <= reload & (pend_ovf_q | (ev & (pend == '1)));
            pend_ovf_q <= 1'b0;
        end else begin
            if (cnt_drop)  ovf_q      <= 1'b1;
            if (pend_drop) pend_ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q & out_valid;
`else
    logic unused_drops;
    assign unused_drops = cnt_drop | pend_drop;
`endif

endmodule

// File: tb/tb_pulse_collector.sv
// Directed bench for pulse_collector: a CW=4/WINDOW=8 instance plus a CW=2/WINDOW=16 instance
// for saturation. Build with PULSE_COLLECTOR_OVF_EN to also cover the ovf port.
module tb_pulse_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse, ready, valid, busy;
    logic [3:0] count;
    logic       pulse2, ready2, valid2, busy2;
    logic [1:0] count2;
`ifdef PULSE_COLLECTOR_OVF_EN
    logic       ovf, ovf2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_collector #(.CW(4), .WINDOW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse),
        .out_ready (ready),
        .out_valid (valid),
        .out_count (count),
        .busy      (busy)
`ifdef PULSE_COLLECTOR_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    pulse_collector #(.CW(2), .WINDOW(16)) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse2),
        .out_ready (ready2),
        .out_valid (valid2),
        .out_count (count2),
        .busy      (busy2)
`ifdef PULSE_COLLECTOR_OVF_EN
        ,
        .ovf       (ovf2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int valid_cycles;
        int seen_count;
        int n;
        bit seen_valid;

        rst_n = 1'b0; pulse = 1'b0; ready = 1'b0; pulse2 = 1'b0; ready2 = 1'b0;

        // 1. reset state, then idle with no input
        repeat (3) tick();
        check("rst_valid", 32'(valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_busy",  32'(busy),  0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", 32'(busy), 0);

        // 2. single pulse, consumer always ready
        pulse = 1'b1; ready = 1'b1;
        tick();                                   // edge E
        pulse = 1'b0;
        check("single_busy", 32'(busy), 1);
        repeat (7) tick();                        // E+7
        check("single_not_yet_valid", 32'(valid), 0);
        tick();                                   // E+8
        check("single_valid", 32'(valid), 1);
        check("single_count", 32'(count), 1);
`ifdef PULSE_COLLECTOR_OVF_EN
        check("single_ovf", 32'(ovf), 0);
`endif
        tick();                                   // handshake edge
        check("single_hs_valid", 32'(valid), 0);
        check("single_hs_idle",  32'(busy),  0);

        // 3. level held high for 20 cycles counts once
        pulse = 1'b1;
        valid_cycles = 0; seen_count = 0;
        repeat (20) begin
            tick();
            if (valid) begin
                valid_cycles++;
                seen_count = int'(count);
            end
        end
        pulse = 1'b0;
        check("level_batches", 32'(valid_cycles), 1);
        check("level_count",   32'(seen_count),   1);
        repeat (2) tick();
        check("level_idle", 32'(busy), 0);

        // 4. events during OFFER seed the next batch
        ready = 1'b0;
        pulse = 1'b1; tick(); pulse = 1'b0;       // edge E
        repeat (8) tick();                        // E+8 -> OFFER
        check("offer_valid", 32'(valid), 1);
        pulse = 1'b1; tick(); pulse = 1'b0; tick();
        pulse = 1'b1; tick(); pulse = 1'b0; tick();
        check("offer_hold_valid", 32'(valid), 1);
        check("offer_hold_count", 32'(count), 1);
        ready = 1'b1;
        tick();                                   // handshake H -> ACCUM with cnt=2
        check("reload_valid", 32'(valid), 0);
        check("reload_busy",  32'(busy),  1);
        repeat (7) tick();
        check("reload_not_yet_valid", 32'(valid), 0);
        tick();                                   // H+8
        check("reload_valid2", 32'(valid), 1);
        check("reload_count",  32'(count), 2);
        tick();
        check("reload_idle", 32'(busy), 0);

        // 5. CW=2, WINDOW=16: five rising edges saturate at 3
        pulse2 = 1'b1; tick();                    // edge E, cnt=1
        n = 0;
        repeat (4) begin
            pulse2 = 1'b0; tick();
            pulse2 = 1'b1; tick();
            n += 2;
        end
        pulse2 = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 40 && !seen_valid; i++) begin
            tick();
            n++;
            seen_valid = valid2;
        end
        check("sat_valid_seen", 32'(seen_valid), 1);
        check("sat_latency",    32'(n),          16);
        check("sat_count",      32'(count2),     3);
`ifdef PULSE_COLLECTOR_OVF_EN
        check("sat_ovf", 32'(ovf2), 1);
`endif
        ready2 = 1'b1;
        tick();
        check("sat_hs_valid", 32'(valid2), 0);
        check("sat_hs_idle",  32'(busy2),  0);
`ifdef PULSE_COLLECTOR_OVF_EN
        check("sat_hs_ovf", 32'(ovf2), 0);
`endif

        // 6. asynchronous reset mid-ACCUM with cnt=2
        ready = 1'b0;
        pulse = 1'b1; tick(); pulse = 1'b0; tick();
        pulse = 1'b1; tick(); pulse = 1'b0; tick();
        check("mid_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(busy),  0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_count", 32'(count), 0);
        tick();
        rst_n = 1'b1; ready = 1'b1;
        valid_cycles = 0;
        repeat (12) begin
            tick();
            if (valid) valid_cycles++;
        end
        check("post_rst_no_valid", 32'(valid_cycles), 0);
        check("post_rst_idle",     32'(busy),         0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
